// File: rtl/trap_arb_pkg.sv
// trap_arb_pkg: shared trap-arbiter encodings (FSM states, cause offset, csr_sel codes, exception codes)
package trap_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_HANDLER = 2'd2} state_t;
  localparam int IRQ_CAUSE_OFF = 16;
  localparam logic [1:0] CSR_MEPC = 2'd0;
  localparam logic [1:0] CSR_MCAUSE = 2'd1;
  localparam logic [1:0] CSR_MTVAL = 2'd2;
  localparam logic [1:0] CSR_PEND = 2'd3;
  localparam logic [4:0] EXC_INSN_MISALIGN = 5'd0;
  localparam logic [4:0] EXC_INSN_FAULT = 5'd1;
  localparam logic [4:0] EXC_ILLEGAL = 5'd2;
  localparam logic [4:0] EXC_BREAKPOINT = 5'd3;
  localparam logic [4:0] EXC_LOAD_FAULT = 5'd5;
  localparam logic [4:0] EXC_STORE_FAULT = 5'd7;
  localparam logic [4:0] EXC_ECALL_M = 5'd11;
endpackage

// File: rtl/trap_arb_irq_sync.sv
// trap_arb_irq_sync: SYNC_STAGES-deep synchroniser for one irq line plus rising-edge detect
module trap_arb_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_irq,
  output logic o_level,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise = o_level & ~r_prev;
endmodule

// File: rtl/trap_arb.sv
// trap_arb: exception/interrupt arbiter with trap CSR capture and fetch-flush handshake.
// Optional KRV_TRAP_VECTORED_EN enables vectored interrupt targets for mtvec_mode 01.
module trap_arb
  import trap_arb_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic [NUM_IRQ-1:0]    irq_in,
  input  logic [NUM_IRQ-1:0]    irq_edge,
  input  logic [NUM_IRQ-1:0]    irq_en,
  input  logic                  mstatus_mie,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [ADDR_WIDTH-1:0] exc_pc,
  input  logic [DATA_WIDTH-1:0] exc_tval,
  input  logic [ADDR_WIDTH-1:0] int_pc,
  input  logic [ADDR_WIDTH-1:0] mtvec_base,
  input  logic [1:0]            mtvec_mode,
  output logic                  trap_req,
  input  logic                  trap_ack,
  output logic [ADDR_WIDTH-1:0] trap_vector,
  input  logic                  mret,
  input  logic                  csr_wr,
  input  logic [1:0]            csr_sel,
  input  logic [DATA_WIDTH-1:0] csr_wdata,
  output logic [ADDR_WIDTH-1:0] mepc,
  output logic [DATA_WIDTH-1:0] mcause,
  output logic [DATA_WIDTH-1:0] mtval,
  output logic [NUM_IRQ-1:0]    irq_pending,
  output logic                  in_handler
);
  state_t r_state, w_next;
  logic [NUM_IRQ-1:0] w_level, w_rise, r_pend, w_pend_nxt, w_elig, w_take_clr, w_w1c;
  logic [ADDR_WIDTH-1:0] r_mepc;
  logic [DATA_WIDTH-1:0] r_mcause, r_mtval;
  logic [3:0] r_idx, w_idx;
  logic r_is_irq, w_hit, w_cap_exc, w_cap_irq, w_csr_ok;
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    trap_arb_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(cpu_clk), .rst(cpu_rst), .i_irq(irq_in[i]), .o_level(w_level[i]), .o_rise(w_rise[i])
    );
  end
  assign in_handler = r_state != ST_IDLE;
  assign trap_req = r_state == ST_REQ;
  assign w_elig = r_pend & irq_en & {NUM_IRQ{mstatus_mie & ~in_handler}};
  assign w_hit = |w_elig;
  always_comb begin
    w_idx = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) if (w_elig[k]) w_idx = 4'(k);
  end
  always_ff @(posedge cpu_clk or posedge cpu_rst)
    if (cpu_rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_cap_exc = 1'b0;
    w_cap_irq = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cap_exc = exc_valid;
        w_cap_irq = ~exc_valid & w_hit;
        w_next = (exc_valid | w_hit) ? ST_REQ : ST_IDLE;
      end
      ST_REQ: w_next = trap_ack ? ST_HANDLER : ST_REQ;
      ST_HANDLER: begin
        w_cap_exc = exc_valid;
        w_next = exc_valid ? ST_REQ : mret ? ST_IDLE : ST_HANDLER;
      end
      default: w_next = ST_IDLE;
    endcase
  end
  // captured trap state is frozen while the request is outstanding
  assign w_csr_ok = csr_wr & (r_state != ST_REQ);
  always_ff @(posedge cpu_clk or posedge cpu_rst)
    if (cpu_rst) begin
      r_mepc <= '0;
      r_mcause <= '1;
      r_mtval <= '0;
      r_idx <= '0;
      r_is_irq <= 1'b0;
    end else if (w_cap_exc) begin
      r_mepc <= exc_pc;
      r_mcause <= DATA_WIDTH'(exc_code);
      r_mtval <= exc_tval;
      r_is_irq <= 1'b0;
    end else if (w_cap_irq) begin
      r_mepc <= int_pc;
      r_mcause <= {1'b1, (DATA_WIDTH-1)'(IRQ_CAUSE_OFF + int'(w_idx))};
      r_idx <= w_idx;
      r_is_irq <= 1'b1;
    end else if (w_csr_ok) begin
      if (csr_sel == CSR_MEPC) r_mepc <= ADDR_WIDTH'(csr_wdata);
      if (csr_sel == CSR_MCAUSE) r_mcause <= csr_wdata;
      if (csr_sel == CSR_MTVAL) r_mtval <= csr_wdata;
    end
  // edge bits: a fresh rise beats both the take-clear and W1C; level bits track the synchronised line
  assign w_take_clr = (trap_req & trap_ack & r_is_irq) ? (NUM_IRQ'(1) << r_idx) : '0;
  assign w_w1c = (csr_wr && csr_sel == CSR_PEND) ? csr_wdata[NUM_IRQ-1:0] : '0;
  assign w_pend_nxt = (irq_edge & (w_rise | (r_pend & ~w_take_clr & ~w_w1c))) | (~irq_edge & w_level);
  always_ff @(posedge cpu_clk or posedge cpu_rst)
    if (cpu_rst) r_pend <= '0;
    else r_pend <= w_pend_nxt;
  assign mepc = r_mepc;
  assign mcause = r_mcause;
  assign mtval = r_mtval;
  assign irq_pending = r_pend;
`ifdef KRV_TRAP_VECTORED_EN
  assign trap_vector = (mtvec_mode == 2'b01 && r_is_irq) ?
                       mtvec_base + ADDR_WIDTH'(4 * (IRQ_CAUSE_OFF + int'(r_idx))) : mtvec_base;
`else
  logic w_unused;
  assign w_unused = ^mtvec_mode;
  assign trap_vector = mtvec_base;
`endif
endmodule
